// File: rtl/pipe_delay_pkg.sv
// ---------------------------------------------------------------------------
// pipe_delay_pkg
// Shared constants and helpers for the elastic delay line.
//   DEF_WIDTH / DEF_DEPTH / DEF_INIT : default parameter values
//   cnt_w(depth)                     : width of the occupancy counter,
//                                      large enough to hold 0..depth
// ---------------------------------------------------------------------------
package pipe_delay_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_INIT  = 0;

    // Occupancy ranges over 0..depth inclusive, hence depth+1 codes.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_delay_if.sv
// ---------------------------------------------------------------------------
// pipe_delay_if
// Ready/valid bundle for both ends of the delay line.
//   I / I_valid / I_ready : producer side (producer drives I, I_valid)
//   O / O_valid / O_ready : consumer side (consumer drives O_ready)
// Modports:
//   slave  : the delay line itself
//   master : the environment (producer + consumer) around it
// ---------------------------------------------------------------------------
interface pipe_delay_if
    import pipe_delay_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] I;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O;
    logic             O_valid;
    logic             O_ready;

    modport slave (
        input  I,
        input  I_valid,
        output I_ready,
        output O,
        output O_valid,
        input  O_ready
    );

    modport master (
        output I,
        output I_valid,
        input  I_ready,
        input  O,
        input  O_valid,
        output O_ready
    );

endinterface

// File: rtl/pipe_delay_stage.sv
// ---------------------------------------------------------------------------
// pipe_delay_stage
// One stage of the elastic delay line: a data register plus its valid bit.
// Ports:
//   CLK       : clock, rising edge
//   RESET     : synchronous active-high reset (valid=0, data=INIT)
//   FLUSH     : synchronous discard (valid=0, data kept)
//   adv       : this stage may take a new entry from upstream this edge
//   in_data   : upstream data
//   in_valid  : upstream valid
//   out_data  : stage data
//   out_valid : stage valid
// ---------------------------------------------------------------------------
module pipe_delay_stage
    import pipe_delay_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             adv,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Priority: reset, then flush, then normal advance.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= 1'b0;
            r_data  <= INIT;
        end else if (FLUSH) begin
            r_valid <= 1'b0;
        end else if (adv) begin
            r_valid <= in_valid;
            // Data only moves with a real entry, so bubbles cause no toggling.
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;

endmodule

// File: rtl/pipe_delay.sv
// ---------------------------------------------------------------------------
// pipe_delay
// Parametrised elastic delay line: DEPTH register stages of WIDTH bits, each
// with its own valid bit, ready/valid flow control at both ends, and bubble
// collapse (an empty stage always takes from upstream, even while the output
// is stalled).
// Parameters:
//   WIDTH : data bits per stage
//   DEPTH : number of stages (>= 1)
//   INIT  : reset value of every stage data register
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset, highest priority
//   FLUSH : synchronous discard of every in-flight entry
//   bus   : pipe_delay_if.slave (I, I_valid, I_ready, O, O_valid, O_ready)
//   COUNT : entries in flight, present only when PIPE_DELAY_COUNT_EN is
//           defined
// Note: I_ready depends combinationally on O_ready through the advance
// chain; there is no skid buffer.
// ---------------------------------------------------------------------------
module pipe_delay
    import pipe_delay_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter int               DEPTH = DEF_DEPTH,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     FLUSH,
    pipe_delay_if.slave              bus
`ifdef PIPE_DELAY_COUNT_EN
    ,
    output logic [cnt_w(DEPTH)-1:0]  COUNT
`endif
);

    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_i_ready;
    logic             w_o_valid;
    logic             w_in_valid;

    // A stage may advance if it, or any stage between it and the output, is
    // empty, or if the consumer is taking the final word. Walking from the
    // output end with a running OR gives adv[k] = !v[k] | adv[k+1].
    always_comb begin
        logic w_chain;
        w_chain = bus.O_ready;
        w_adv   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_chain  = w_chain | ~w_valid[k];
            w_adv[k] = w_chain;
        end
    end

    // No handshake completes on either side during a flush.
    assign w_i_ready  = w_adv[0] & ~FLUSH;
    assign w_o_valid  = w_valid[DEPTH-1] & ~FLUSH;
    assign w_in_valid = bus.I_valid & w_i_ready;

    assign bus.I_ready = w_i_ready;
    assign bus.O_valid = w_o_valid;
    assign bus.O       = w_data[DEPTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                pipe_delay_stage #(
                    .WIDTH (WIDTH),
                    .INIT  (INIT)
                ) u_stage (
                    .CLK       (CLK),
                    .RESET     (RESET),
                    .FLUSH     (FLUSH),
                    .adv       (w_adv[gi]),
                    .in_data   (bus.I),
                    .in_valid  (w_in_valid),
                    .out_data  (w_data[gi]),
                    .out_valid (w_valid[gi])
                );
            end else begin : g_rest
                pipe_delay_stage #(
                    .WIDTH (WIDTH),
                    .INIT  (INIT)
                ) u_stage (
                    .CLK       (CLK),
                    .RESET     (RESET),
                    .FLUSH     (FLUSH),
                    .adv       (w_adv[gi]),
                    .in_data   (w_data[gi-1]),
                    .in_valid  (w_valid[gi-1]),
                    .out_data  (w_data[gi]),
                    .out_valid (w_valid[gi])
                );
            end
        end
    endgenerate

`ifdef PIPE_DELAY_COUNT_EN
    localparam int CW = cnt_w(DEPTH);

    logic [CW-1:0] r_count;
    logic          w_in_hs;
    logic          w_out_hs;

    assign w_in_hs  = w_in_valid;
    assign w_out_hs = w_o_valid & bus.O_ready;

    // Simultaneous in and out handshakes leave the occupancy unchanged.
    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            r_count <= '0;
        end else if (w_in_hs && !w_out_hs) begin
            r_count <= r_count + 1'b1;
        end else if (!w_in_hs && w_out_hs) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign COUNT = r_count;
`endif

endmodule

// File: tb/tb_pipe_delay.sv
// ---------------------------------------------------------------------------
// tb_pipe_delay
// Self-checking bench for pipe_delay (WIDTH=4, DEPTH=4, INIT=0).
// A driver applies directed scenarios followed by random traffic. A monitor
// on the falling edge keeps a queue of in-flight words; each word becomes
// visible at the output DEPTH-1 edges after its acceptance edge, or on the
// edge its predecessor leaves, whichever is later. I_ready is expected
// whenever the line is not full or the consumer is ready. Occupancy checks
// apply when PIPE_DELAY_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipe_delay;
    import pipe_delay_pkg::*;

    localparam int               WIDTH = 4;
    localparam int               DEPTH = 4;
    localparam logic [WIDTH-1:0] INIT  = '0;

    logic CLK = 1'b0;
    logic RESET;
    logic FLUSH;

    pipe_delay_if #(.WIDTH(WIDTH)) bus ();

`ifdef PIPE_DELAY_COUNT_EN
    logic [cnt_w(DEPTH)-1:0] COUNT;
`endif

    pipe_delay #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INIT  (INIT)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .FLUSH (FLUSH),
        .bus   (bus)
`ifdef PIPE_DELAY_COUNT_EN
        ,
        .COUNT (COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;   // acceptance edge
    } word_t;

    word_t            q[$];
    int               cyc       = 0;
    int               checks    = 0;
    int               failures  = 0;
    bit               chk_en    = 1'b0;
    int               last_pop  = 0;
    logic [WIDTH-1:0] last_d    = INIT;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin : mon
        int               arrive;
        bit               head_vis;
        bit               exp_ov;
        bit               exp_ir;
        logic [WIDTH-1:0] exp_o;

        head_vis = 1'b0;
        if (q.size() > 0) begin
            arrive   = (q[0].t + DEPTH - 1 > last_pop) ? q[0].t + DEPTH - 1 : last_pop;
            head_vis = (cyc >= arrive);
        end
        exp_ov = head_vis && !FLUSH;
        exp_ir = !FLUSH && ((q.size() < DEPTH) || bus.O_ready);
        exp_o  = head_vis ? q[0].d : last_d;

        if (chk_en) begin
            check("o_valid", {31'd0, bus.O_valid}, {31'd0, exp_ov});
            check("i_ready", {31'd0, bus.I_ready}, {31'd0, exp_ir});
            check("o_data",  {28'd0, bus.O},       {28'd0, exp_o});
`ifdef PIPE_DELAY_COUNT_EN
            check("count", {{(32-cnt_w(DEPTH)){1'b0}}, COUNT}, q.size());
            checks++;
            assert (int'(COUNT) == $countones(dut.w_valid))
            else begin
                failures++;
                $display("FAIL count_popcount actual=%0d expected=%0d cycle=%0d",
                         COUNT, $countones(dut.w_valid), cyc);
            end
`endif
        end

        if (RESET) begin
            q.delete();
            last_d   = INIT;
            last_pop = 0;
            chk_en   = 1'b1;
        end else if (FLUSH) begin
            if (head_vis) last_d = q[0].d;
            q.delete();
            last_pop = 0;
        end else begin
            if (exp_ov && bus.O_ready) begin
                $display("OUT  data=%h edge=%0d", q[0].d, cyc + 1);
                last_d   = q[0].d;
                last_pop = cyc + 1;
                void'(q.pop_front());
            end
            if (bus.I_valid && exp_ir) begin
                $display("IN   data=%h edge=%0d", bus.I, cyc + 1);
                q.push_back('{d: bus.I, t: cyc + 1});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                        input logic fl, input logic rst);
        bus.I_valid = v;
        bus.I       = d;
        bus.O_ready = ordy;
        FLUSH       = fl;
        RESET       = rst;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus.I_valid = 1'b0;
        bus.I       = '0;
        bus.O_ready = 1'b0;
        FLUSH       = 1'b0;
        RESET       = 1'b1;

        // Reset held for two cycles
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_o",       {28'd0, bus.O}, 32'd0);
        check("rst_o_valid", {31'd0, bus.O_valid}, 32'd0);
        check("rst_i_ready", {31'd0, bus.I_ready}, 32'd1);
`ifdef PIPE_DELAY_COUNT_EN
        check("rst_count", {{(32-cnt_w(DEPTH)){1'b0}}, COUNT}, 32'd0);
`endif

        // Streaming 1..5 with the consumer always ready
        for (int i = 1; i <= 5; i++) step(1, 4'(i), 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);

        // Backpressure: six offers into a stalled line, four accepted
        for (int i = 0; i < 6; i++) step(1, 4'(6 + i), 0, 0, 0);
        check("full_i_ready", {31'd0, bus.I_ready}, 32'd0);
`ifdef PIPE_DELAY_COUNT_EN
        check("full_count", {{(32-cnt_w(DEPTH)){1'b0}}, COUNT}, 32'd4);
`endif
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);

        // Bubble collapse: A, idle, B while stalled
        step(1, 4'hA, 0, 0, 0);
        step(0, 0,    0, 0, 0);
        step(1, 4'hB, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        check("bubble_valid_vec", {28'd0, dut.w_valid}, 32'hC);
        check("bubble_i_ready",   {31'd0, bus.I_ready}, 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

        // Flush with three words in flight; offer during the flush is refused
        for (int i = 1; i <= 3; i++) step(1, 4'(i), 0, 0, 0);
        step(1, 4'h7, 0, 1, 0);
        check("flush_o_valid", {31'd0, bus.O_valid}, 32'd0);
`ifdef PIPE_DELAY_COUNT_EN
        check("flush_count", {{(32-cnt_w(DEPTH)){1'b0}}, COUNT}, 32'd0);
`endif
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);

        // Reset with the line full
        for (int i = 0; i < 5; i++) step(1, 4'(12 + i), 0, 0, 0);
        step(1, 4'h5, 0, 0, 1);
        check("midrst_o_valid", {31'd0, bus.O_valid}, 32'd0);
        check("midrst_o",       {28'd0, bus.O}, 32'd0);
        check("midrst_i_ready", {31'd0, bus.I_ready}, 32'd1);
        step(1, 4'h9, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 199) < 2));
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
